instr_buffer: RTL and testbench

INSTR_BUFFER -- requirements
Module: instr_buffer

---
 rtl/instr_buffer.sv | 133 +++++++++++++
 tb/tb_instr_buffer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode: circular FIFO with compacting push.
// Optional perf counter output empty_cycles_o is enabled with INSTR_BUFFER_PERF_EN.
package instr_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
        logic [5:0]  excp_num;
        logic [5:0]  ftq_id;
        logic        is_last_in_block;
        logic [7:0]  special_info;
    } instr_info_t;
endpackage

module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int FETCH_WIDTH  = 4,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  instr_info_t [FETCH_WIDTH-1:0] frontend_instr_i,
    output logic                          frontend_ready_o,
    output instr_info_t [DECODE_WIDTH-1:0] backend_instr_o,
    input  logic [DECODE_WIDTH-1:0]       backend_accept_i,
    input  logic                          backend_flush_i
`ifdef INSTR_BUFFER_PERF_EN
    ,
    output logic [31:0]                   empty_cycles_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    instr_info_t   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [PW-1:0] wr_idx [FETCH_WIDTH];
    logic [CW-1:0] push_cnt;
    logic [CW-1:0] pop_cnt;
    logic          push_en;

    // Ready looks only at the registered occupancy, never at this cycle's pop.
    assign frontend_ready_o = (count <= CW'(DEPTH - FETCH_WIDTH));
    assign push_en = frontend_ready_o && !backend_flush_i;

    // Compact valid lanes: each valid lane lands after all lower valid lanes.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_idx[i] = tail + push_cnt[PW-1:0];
            if (frontend_instr_i[i].valid) begin
                push_cnt = push_cnt + CW'(1);
            end
        end
        if (!push_en) begin
            push_cnt = '0;
        end
    end

    // Pop the unbroken run of accepted, valid lanes starting at lane 0.
    always_comb begin
        logic run;
        pop_cnt = '0;
        run     = 1'b1;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (run && backend_accept_i[i] && (count > CW'(i))) begin
                pop_cnt = pop_cnt + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Oldest entries to decode; lanes past the occupancy read as all-zero.
    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (count > CW'(i)) begin
                backend_instr_o[i] = mem[head + PW'(i)];
            end else begin
                backend_instr_o[i] = '0;
            end
        end
    end

    // Storage write; contents are not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (frontend_instr_i[i].valid) begin
                    mem[wr_idx[i]] <= frontend_instr_i[i];
                end
            end
        end
    end

    // Pointer and occupancy update; flush drops this cycle's push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (backend_flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + pop_cnt[PW-1:0];
            tail  <= tail + push_cnt[PW-1:0];
            count <= count + push_cnt - pop_cnt;
        end
    end

`ifdef INSTR_BUFFER_PERF_EN
    // Saturating count of idle (empty, unflushed) cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            empty_cycles_o <= '0;
        end else if (count == '0 && !backend_flush_i
                     && empty_cycles_o != 32'hFFFF_FFFF) begin
            empty_cycles_o <= empty_cycles_o + 32'd1;
        end
    end
`else
    // No performance counter in this build.
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer against a queue-based reference model.
// Directed scenarios followed by randomized push/accept/flush traffic.
module tb_instr_buffer;
    import instr_buffer_pkg::*;

    localparam int FW = 4;
    localparam int DW = 2;
    localparam int D  = 16;

    logic                 clk;
    logic                 rst_n;
    instr_info_t [FW-1:0] fe_r;
    logic                 ready;
    instr_info_t [DW-1:0] be;
    logic [DW-1:0]        acc_r;
    logic                 fl_r;
`ifdef INSTR_BUFFER_PERF_EN
    logic [31:0]          empty_cycles;
`endif

    instr_info_t q[$];
    int n_cmp;
    int n_bad;

    instr_buffer #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(D)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frontend_instr_i (fe_r),
        .frontend_ready_o (ready),
        .backend_instr_o  (be),
        .backend_accept_i (acc_r),
        .backend_flush_i  (fl_r)
`ifdef INSTR_BUFFER_PERF_EN
        ,
        .empty_cycles_o   (empty_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_info_t mk(input logic [31:0] pc);
        instr_info_t s;
        s.valid            = 1'b1;
        s.pc               = pc;
        s.instr            = $urandom;
        s.excp             = 1'($urandom_range(0, 1));
        s.excp_num         = 6'($urandom);
        s.ftq_id           = 6'($urandom);
        s.is_last_in_block = 1'($urandom_range(0, 1));
        s.special_info     = 8'($urandom);
        return s;
    endfunction

    // Drive one cycle of stimulus and advance the reference model at the edge.
    task automatic apply(input instr_info_t [FW-1:0] fe,
                         input logic [DW-1:0] acc, input logic fl);
        int n;
        bit rdy;
        rdy   = (D - q.size()) >= FW;
        fe_r  = fe;
        acc_r = acc;
        fl_r  = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            n = 0;
            for (int i = 0; i < DW; i++) begin
                if (acc[i] && i < q.size()) n++;
                else break;
            end
            repeat (n) void'(q.pop_front());
            if (rdy) begin
                for (int i = 0; i < FW; i++)
                    if (fe[i].valid) q.push_back(fe[i]);
            end
        end
        #1;
        fe_r  = '0;
        acc_r = '0;
        fl_r  = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [31:0] pc0);
        instr_info_t [FW-1:0] fe;
        fe = '0;
        for (int i = 0; i < n; i++) fe[i] = mk(pc0 + 32'(4 * i));
        apply(fe, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        instr_info_t exp;
        rst_n = 1'b0;
        fe_r  = '0;
        acc_r = '0;
        fl_r  = 1'b0;
        #2;
        n_cmp++;
        if (ready !== 1'b1 || be !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: ready=%b lanes=%h want ready=1 lanes=0", ready, be);
        end
        do_reset();
        push_n(4, 32'h100);
        push_n(3, 32'h200);
        for (int i = 0; i < FW; i++) fe_r[i] = mk(32'h300 + 32'(i));
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b1 || be !== '0 || dut.count !== '0) begin
            n_bad++;
            $display("FAIL reset_async: ready=%b cnt=%0d lanes=%h want 1/0/0", ready, dut.count, be);
        end
        @(posedge clk);
        #1;
        fe_r  = '0;
        rst_n = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        exp = '0;
        n_cmp++;
        if (be[0] !== exp || dut.count !== '0) begin
            n_bad++;
            $display("FAIL reset_after: cnt=%0d lane0=%h want 0", dut.count, be[0]);
        end
    endtask

    task automatic test_basic();
        do_reset();
        push_n(4, 32'h1c00_0000);
        n_cmp++;
        if (be[0].pc !== 32'h1c00_0000 || be[1].pc !== 32'h1c00_0004
            || be[0] !== q[0] || be[1] !== q[1] || dut.count !== 4) begin
            n_bad++;
            $display("FAIL basic_push: pc0=%h pc1=%h cnt=%0d want 1c000000/1c000004/4",
                     be[0].pc, be[1].pc, dut.count);
        end
    endtask

    task automatic test_holes();
        instr_info_t [FW-1:0] fe;
        do_reset();
        fe    = '0;
        fe[0] = mk(32'hA000);
        fe[2] = mk(32'hC000);
        apply(fe, '0, 1'b0);
        n_cmp++;
        if (be[0] !== fe[0] || be[1] !== fe[2] || dut.count !== 2) begin
            n_bad++;
            $display("FAIL holes: pc0=%h pc1=%h cnt=%0d want A000/C000/2",
                     be[0].pc, be[1].pc, dut.count);
        end
    endtask

    task automatic test_wrap();
        instr_info_t [FW-1:0] fe;
        int bad;
        do_reset();
        push_n(4, 32'h0);
        push_n(4, 32'h10);
        push_n(4, 32'h20);
        for (int i = 0; i < FW; i++) fe[i] = mk(32'h30 + 32'(4 * i));
        apply(fe, 2'b11, 1'b0);
        n_cmp++;
        if (dut.count !== 14 || q.size() != 14) begin
            n_bad++;
            $display("FAIL wrap_count: cnt=%0d want 14", dut.count);
        end
        bad = 0;
        for (int k = 0; k < 7; k++) begin
            if (be[0] !== q[0] || be[1] !== q[1]) bad++;
            apply('0, 2'b11, 1'b0);
        end
        n_cmp++;
        if (bad != 0 || be !== '0) begin
            n_bad++;
            $display("FAIL wrap_drain: bad_cycles=%0d lanes=%h want 0", bad, be);
        end
    endtask

    task automatic test_full();
        instr_info_t sv0;
        instr_info_t sv1;
        do_reset();
        push_n(4, 32'h0);
        push_n(4, 32'h10);
        push_n(4, 32'h20);
        push_n(1, 32'h30);
        sv0 = be[0];
        sv1 = be[1];
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full13_ready: ready=%b want 0", ready);
        end
        push_n(4, 32'h40);
        n_cmp++;
        if (dut.count !== 13 || be[0] !== sv0 || be[1] !== sv1 || be[0] !== q[0]) begin
            n_bad++;
            $display("FAIL full13_push: cnt=%0d pc0=%h want 13 / %h",
                     dut.count, be[0].pc, sv0.pc);
        end
        do_reset();
        push_n(4, 32'h0);
        push_n(4, 32'h10);
        push_n(4, 32'h20);
        push_n(4, 32'h30);
        n_cmp++;
        if (dut.count !== 16 || ready !== 1'b0 || be[0] !== q[0] || be[1] !== q[1]) begin
            n_bad++;
            $display("FAIL full16: cnt=%0d ready=%b want 16/0", dut.count, ready);
        end
    endtask

    task automatic test_pop_rules();
        do_reset();
        push_n(1, 32'h500);
        apply('0, 2'b11, 1'b0);
        n_cmp++;
        if (dut.count !== 0 || be !== '0) begin
            n_bad++;
            $display("FAIL pop_one: cnt=%0d want 0", dut.count);
        end
        push_n(3, 32'h600);
        apply('0, 2'b10, 1'b0);
        n_cmp++;
        if (dut.count !== 3 || be[0] !== q[0] || be[0].pc !== 32'h600) begin
            n_bad++;
            $display("FAIL pop_gap: cnt=%0d pc0=%h want 3/600", dut.count, be[0].pc);
        end
    endtask

    task automatic test_flush();
        instr_info_t [FW-1:0] fe;
        do_reset();
        push_n(4, 32'h0);
        push_n(4, 32'h10);
        push_n(1, 32'h20);
        for (int i = 0; i < FW; i++) fe[i] = mk(32'h70 + 32'(4 * i));
        apply(fe, 2'b11, 1'b1);
        n_cmp++;
        if (dut.count !== 0 || be !== '0 || ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush: cnt=%0d lanes=%h want 0", dut.count, be);
        end
        push_n(2, 32'h900);
        n_cmp++;
        if (be[0] !== q[0] || be[1] !== q[1] || be[1].pc !== 32'h904) begin
            n_bad++;
            $display("FAIL flush_refill: pc0=%h pc1=%h want 900/904", be[0].pc, be[1].pc);
        end
    endtask

    task automatic test_random();
        instr_info_t [FW-1:0] fe;
        instr_info_t exp;
        logic [31:0] pc;
        do_reset();
        pc = 32'h8000_0000;
        for (int c = 0; c < 400; c++) begin
            n_cmp++;
            if (ready !== ((D - q.size()) >= FW) || dut.count !== q.size()) begin
                n_bad++;
                $display("FAIL rand_ready c=%0d: ready=%b cnt=%0d want cnt=%0d",
                         c, ready, dut.count, q.size());
            end
            for (int i = 0; i < DW; i++) begin
                exp = (i < q.size()) ? q[i] : '0;
                n_cmp++;
                if (be[i] !== exp) begin
                    n_bad++;
                    $display("FAIL rand_lane%0d c=%0d: got %h want %h", i, c, be[i], exp);
                end
            end
            fe = '0;
            for (int i = 0; i < FW; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    fe[i] = mk(pc);
                    pc = pc + 32'd4;
                end
            end
            apply(fe, DW'($urandom), ($urandom_range(0, 29) == 0));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_holes();
        test_wrap();
        test_full();
        test_pop_rules();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
